pc_src_controller: RTL and testbench

Sequencer that drives the 2-bit PC-source select of the fetch-stage PC mux and related pipeline controls for the 8-bit pipelined processor. It arbitrates redirect requests: sequential fetch, taken jump/call, RET/RTI from stack, and vector fetch from M[0] (reset) or M[1] (interrupt). It also handles the multi-cycle reset-vector and interrupt-entry sequences. It sits between the hazard unit, the EX/MEM-stage control, and the fetch-stage PC register.

---
 rtl/pc_src_controller_if.sv | 28 ++
 rtl/pc_src_controller.sv | 124 ++++++++++++
 tb/tb_pc_src_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_src_controller_if.sv
// pc_src_controller_if: redirect requests in, PC-mux select and pipeline controls out
interface pc_src_controller_if;
    logic       jmp_taken;
    logic       ret_req;
    logic       rti;
    logic       intr;
    logic       pipe_hold;
    logic [1:0] pc_src;
    logic       vec_sel;
    logic       vec_rd;
    logic       pc_en;
    logic       flush;
    logic       int_push;
    logic       flags_save;
    logic       flags_restore;
    logic       int_ack;
    logic       int_en;
    modport slave (
        input  jmp_taken, ret_req, rti, intr, pipe_hold,
        output pc_src, vec_sel, vec_rd, pc_en, flush, int_push,
               flags_save, flags_restore, int_ack, int_en
    );
    modport master (
        output jmp_taken, ret_req, rti, intr, pipe_hold,
        input  pc_src, vec_sel, vec_rd, pc_en, flush, int_push,
               flags_save, flags_restore, int_ack, int_en
    );
endinterface

// File: rtl/pc_src_controller.sv
// pc_src_controller: fetch PC-source sequencer for reset/interrupt vectors, jumps and returns
module pc_src_controller #(
    parameter int VEC_LAT     = 1,
    parameter bit INT_EN_INIT = 1'b1
) (
    input logic                clk,
    input logic                rst,
    pc_src_controller_if.slave bus
);
    localparam logic [2:0] VEC_ADDR = 3'd0;
    localparam logic [2:0] VEC_WAIT = 3'd1;
    localparam logic [2:0] VEC_LOAD = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] INT_PUSH = 3'd4;
    localparam logic [1:0] LAT_M1   = 2'(VEC_LAT - 1);
    logic [2:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic       intr_q, intr_d;
    logic       vec_flag_q, vec_flag_d;
    logic       int_en_q, int_en_d;
    logic       intr_edge;
    logic       take_int;
    assign intr_edge = bus.intr & ~intr_q;
    assign take_int  = pending_q & int_en_q & ~bus.pipe_hold;
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        pending_d         = pending_q | intr_edge;
        intr_d            = bus.intr;
        vec_flag_d        = vec_flag_q;
        int_en_d          = int_en_q;
        bus.pc_src        = 2'b00;
        bus.vec_sel       = 1'b0;
        bus.vec_rd        = 1'b0;
        bus.pc_en         = 1'b0;
        bus.flush         = 1'b0;
        bus.int_push      = 1'b0;
        bus.flags_save    = 1'b0;
        bus.flags_restore = 1'b0;
        bus.int_ack       = 1'b0;
        bus.int_en        = int_en_q;
        case (state_q)
            VEC_ADDR: begin
                bus.vec_rd  = 1'b1;
                bus.vec_sel = vec_flag_q;
                bus.flush   = 1'b1;
                cnt_d       = LAT_M1;
                state_d     = (VEC_LAT == 1) ? VEC_LOAD : VEC_WAIT;
            end
            VEC_WAIT: begin
                bus.flush = 1'b1;
                cnt_d     = cnt_q - 2'd1;
                state_d   = (cnt_q <= 2'd1) ? VEC_LOAD : VEC_WAIT;
            end
            VEC_LOAD: begin
                bus.pc_src = 2'b11;
                bus.pc_en  = 1'b1;
                bus.flush  = 1'b1;
                vec_flag_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                // RET is the older instruction, so a same-cycle jump is squashed
                if (bus.ret_req) begin
                    bus.pc_src        = 2'b10;
                    bus.pc_en         = 1'b1;
                    bus.flush         = 1'b1;
                    bus.flags_restore = bus.rti;
                    int_en_d          = int_en_q | bus.rti;
                end else if (bus.jmp_taken) begin
                    bus.pc_src = 2'b01;
                    bus.pc_en  = 1'b1;
                    bus.flush  = 1'b1;
                end else if (take_int) begin
                    bus.flush = 1'b1;
                    state_d   = INT_PUSH;
                end else begin
                    bus.pc_en = ~bus.pipe_hold;
                end
            end
            INT_PUSH: begin
                bus.int_push   = 1'b1;
                bus.flags_save = 1'b1;
                bus.int_ack    = 1'b1;
                bus.flush      = 1'b1;
                int_en_d       = 1'b0;
                pending_d      = intr_edge;
                vec_flag_d     = 1'b1;
                state_d        = VEC_ADDR;
            end
            default: state_d = VEC_ADDR;
        endcase
        if (rst) begin
            bus.pc_src        = 2'b00;
            bus.vec_sel       = 1'b0;
            bus.vec_rd        = 1'b0;
            bus.pc_en         = 1'b0;
            bus.flush         = 1'b0;
            bus.int_push      = 1'b0;
            bus.flags_save    = 1'b0;
            bus.flags_restore = 1'b0;
            bus.int_ack       = 1'b0;
            bus.int_en        = INT_EN_INIT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= VEC_ADDR;
            cnt_q      <= 2'd0;
            pending_q  <= 1'b0;
            intr_q     <= 1'b0;
            vec_flag_q <= 1'b0;
            int_en_q   <= INT_EN_INIT;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            intr_q     <= intr_d;
            vec_flag_q <= vec_flag_d;
            int_en_q   <= int_en_d;
        end
    end
endmodule

// File: tb/tb_pc_src_controller.sv
// tb_pc_src_controller: directed vectors on three latency variants, checked through a scoreboard queue
module tb_pc_src_controller;
    // input packing {rst, jmp_taken, ret_req, rti, intr, pipe_hold}
    localparam logic [5:0] N    = 6'b000000;
    localparam logic [5:0] RST  = 6'b100000;
    localparam logic [5:0] JMP  = 6'b010000;
    localparam logic [5:0] RET  = 6'b001000;
    localparam logic [5:0] RTI  = 6'b000100;
    localparam logic [5:0] INTR = 6'b000010;
    localparam logic [5:0] HOLD = 6'b000001;
    // output packing {pc_src[1:0], vec_sel, vec_rd, pc_en, flush, int_push, flags_save, flags_restore, int_ack, int_en}
    localparam logic [10:0] O_RST   = 11'b00_0_0_0_0_0_0_0_0_1;
    localparam logic [10:0] O_ADDR0 = 11'b00_0_1_0_1_0_0_0_0_1;
    localparam logic [10:0] O_ADDR1 = 11'b00_1_1_0_1_0_0_0_0_0;
    localparam logic [10:0] O_WAIT1 = 11'b00_0_0_0_1_0_0_0_0_1;
    localparam logic [10:0] O_WAIT0 = 11'b00_0_0_0_1_0_0_0_0_0;
    localparam logic [10:0] O_LOAD1 = 11'b11_0_0_1_1_0_0_0_0_1;
    localparam logic [10:0] O_LOAD0 = 11'b11_0_0_1_1_0_0_0_0_0;
    localparam logic [10:0] O_RUN1  = 11'b00_0_0_1_0_0_0_0_0_1;
    localparam logic [10:0] O_RUN0  = 11'b00_0_0_1_0_0_0_0_0_0;
    localparam logic [10:0] O_JMP   = 11'b01_0_0_1_1_0_0_0_0_1;
    localparam logic [10:0] O_HOLD  = 11'b00_0_0_0_0_0_0_0_0_1;
    localparam logic [10:0] O_RET   = 11'b10_0_0_1_1_0_0_0_0_1;
    localparam logic [10:0] O_RTI0  = 11'b10_0_0_1_1_0_0_1_0_0;
    localparam logic [10:0] O_ACC   = 11'b00_0_0_0_1_0_0_0_0_1;
    localparam logic [10:0] O_PUSH  = 11'b00_0_0_0_1_1_1_0_1_1;
    typedef struct {
        int          cyc;
        int          d;
        string       nm;
        logic [10:0] e;
    } exp_t;
    logic        clk = 1'b0;
    logic [2:0]  rst_v, jmp_v, ret_v, rti_v, intr_v, hold_v;
    logic [10:0] out_v [3];
    exp_t        sb[$];
    exp_t        mon_x;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pc_src_controller_if bus ();
        assign bus.jmp_taken = jmp_v[g];
        assign bus.ret_req   = ret_v[g];
        assign bus.rti       = rti_v[g];
        assign bus.intr      = intr_v[g];
        assign bus.pipe_hold = hold_v[g];
        pc_src_controller #(.VEC_LAT(g + 1), .INT_EN_INIT(1'b1)) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus.slave)
        );
        assign out_v[g] = {bus.pc_src, bus.vec_sel, bus.vec_rd, bus.pc_en, bus.flush, bus.int_push,
                           bus.flags_save, bus.flags_restore, bus.int_ack, bus.int_en};
    end
    task automatic vec(input int d, input string nm, input logic [5:0] in, input logic [10:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        {rst_v[d], jmp_v[d], ret_v[d], rti_v[d], intr_v[d], hold_v[d]} = in;
        x.cyc = cyc;
        x.d   = d;
        x.nm  = nm;
        x.e   = e;
        sb.push_back(x);
    endtask
    initial begin
        @(negedge clk);
        forever begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_x = sb.pop_front();
                vectors++;
                if (out_v[mon_x.d] !== mon_x.e) begin
                    miscompares++;
                    $display("FAIL %s dut%0d cyc %0d: got %b expected %b",
                             mon_x.nm, mon_x.d, mon_x.cyc, out_v[mon_x.d], mon_x.e);
                end
            end
            @(negedge clk);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
    initial begin
        rst_v  = 3'b111;
        jmp_v  = 3'b000;
        ret_v  = 3'b000;
        rti_v  = 3'b000;
        intr_v = 3'b000;
        hold_v = 3'b000;
        // VEC_LAT=1: reset vector, redirects, masking, hold deferral, merge and set-wins
        vec(0, "reset_a",       RST,            O_RST);
        vec(0, "reset_b",       RST,            O_RST);
        vec(0, "rv_addr",       N,              O_ADDR0);
        vec(0, "rv_load",       N,              O_LOAD1);
        vec(0, "rv_run",        N,              O_RUN1);
        vec(0, "jump",          JMP,            O_JMP);
        vec(0, "hold",          HOLD,           O_HOLD);
        vec(0, "ret",           RET,            O_RET);
        vec(0, "intr_edge",     INTR,           O_RUN1);
        vec(0, "accept",        INTR,           O_ACC);
        vec(0, "int_push",      N,              O_PUSH);
        vec(0, "iv_addr",       N,              O_ADDR1);
        vec(0, "iv_load",       N,              O_LOAD0);
        vec(0, "masked_a",      INTR,           O_RUN0);
        vec(0, "masked_b",      N,              O_RUN0);
        vec(0, "masked_c",      INTR,           O_RUN0);
        vec(0, "masked_d",      N,              O_RUN0);
        vec(0, "rti_jmp",       RET | RTI | JMP, O_RTI0);
        vec(0, "held_a",        HOLD,           O_HOLD);
        vec(0, "held_b",        HOLD,           O_HOLD);
        vec(0, "accept2",       N,              O_ACC);
        vec(0, "push_edge",     INTR,           O_PUSH);
        vec(0, "iv2_addr",      N,              O_ADDR1);
        vec(0, "iv2_load",      N,              O_LOAD0);
        vec(0, "rti2",          RET | RTI,      O_RTI0);
        vec(0, "kept_accept",   N,              O_ACC);
        vec(0, "push3",         N,              O_PUSH);
        vec(0, "iv3_addr",      N,              O_ADDR1);
        vec(0, "iv3_load",      N,              O_LOAD0);
        vec(0, "rti3",          RET | RTI,      O_RTI0);
        vec(0, "no_spurious",   N,              O_RUN1);
        vec(0, "park0",         RST,            O_RST);
        // VEC_LAT=2: interrupt entry timing
        vec(1, "l2_reset",      RST,            O_RST);
        vec(1, "l2_addr",       N,              O_ADDR0);
        vec(1, "l2_wait",       N,              O_WAIT1);
        vec(1, "l2_load",       N,              O_LOAD1);
        vec(1, "l2_run",        N,              O_RUN1);
        vec(1, "l2_edge",       INTR,           O_RUN1);
        vec(1, "l2_accept",     N,              O_ACC);
        vec(1, "l2_push",       N,              O_PUSH);
        vec(1, "l2_iv_addr",    N,              O_ADDR1);
        vec(1, "l2_iv_wait",    N,              O_WAIT0);
        vec(1, "l2_iv_load",    N,              O_LOAD0);
        vec(1, "l2_run_masked", N,              O_RUN0);
        vec(1, "park1",         RST,            O_RST);
        // VEC_LAT=3: reset during the interrupt vector wait
        vec(2, "l3_reset",      RST,            O_RST);
        vec(2, "l3_addr",       N,              O_ADDR0);
        vec(2, "l3_wait_a",     N,              O_WAIT1);
        vec(2, "l3_wait_b",     N,              O_WAIT1);
        vec(2, "l3_load",       N,              O_LOAD1);
        vec(2, "l3_edge",       INTR,           O_RUN1);
        vec(2, "l3_accept",     N,              O_ACC);
        vec(2, "l3_push_edge",  INTR,           O_PUSH);
        vec(2, "l3_iv_addr",    N,              O_ADDR1);
        vec(2, "l3_iv_wait",    N,              O_WAIT0);
        vec(2, "l3_mid_reset",  RST,            O_RST);
        vec(2, "l3_re_addr",    N,              O_ADDR0);
        vec(2, "l3_re_wait_a",  N,              O_WAIT1);
        vec(2, "l3_re_wait_b",  N,              O_WAIT1);
        vec(2, "l3_re_load",    N,              O_LOAD1);
        vec(2, "l3_no_pend_a",  N,              O_RUN1);
        vec(2, "l3_no_pend_b",  N,              O_RUN1);
        vec(2, "park2",         RST,            O_RST);
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
